// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic PS2_IDLE_LEVEL = 1'b1;

  // True when the reduced data XOR plus the parity bit matches the selected parity sense.
  function automatic logic parity_ok(input logic data_xor, input logic parity_bit,
                                     input logic odd_parity);
    return (data_xor ^ parity_bit) == odd_parity;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 pin.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);

  localparam int unsigned CW = $clog2(FILTER_LEN);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      sync1_q <= PS2_IDLE_LEVEL;
      sync2_q <= PS2_IDLE_LEVEL;
      filt_q  <= PS2_IDLE_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample equal to the current level restarts the run.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync2_q;
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  assign o_filt = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// Oversampled PS/2 device-to-host receiver with frame checks and a scan-code FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter bit          ODD_PARITY     = 1'b1,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                 i_clock,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_code,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_timeout,
  output logic                 o_overflow
);

  localparam int unsigned BCW = $clog2(DATA_BITS + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;

  logic clk_filt, data_filt, clk_prev_q, fall;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clock(i_clock), .reset(reset), .i_raw(ps2_clk), .o_filt(clk_filt)
  );

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .i_clock(i_clock), .reset(reset), .i_raw(ps2_data), .o_filt(data_filt)
  );

  assign fall = clk_prev_q & ~clk_filt;

  ps2_state_e           state_q, state_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, to_q, to_d, ovf_q, ovf_d;
  logic                 push, push_ok, pop, full, empty;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      clk_prev_q <= PS2_IDLE_LEVEL;
      state_q    <= IDLE;
      bcnt_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      to_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      clk_prev_q <= clk_filt;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      to_q       <= to_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  // Frame FSM: steps on filtered clock falls; the timeout is the only other exit.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    to_d    = 1'b0;
    push    = 1'b0;

    if (fall || state_q == IDLE)         tcnt_d = '0;
    else if (tcnt_q != TCW'(TIMEOUT_CYCLES)) tcnt_d = tcnt_q + TCW'(1);

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_filt) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            ferr_d  = 1'b1;
          end
        end
        DATA: begin
          // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
          shift_d = {data_filt, shift_q[DATA_BITS-1:1]};
          bcnt_d  = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_filt;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_filt)                                 ferr_d = 1'b1;
          else if (!parity_ok(^shift_q, par_q, ODD_PARITY)) perr_d = 1'b1;
          else                                            push   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      to_d    = 1'b1;
    end
  end

  // FIFO: a pop frees the head slot in the same cycle, so a full FIFO can still accept.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = !empty && i_ready;
    push_ok  = push && (!full || pop);
    ovf_d    = push && full && !pop;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  assign o_valid      = !empty;
  assign o_code       = mem_q[rd_ptr_q[AW-1:0]];
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_timeout    = to_q;
  assign o_overflow   = ovf_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the first-generation keyboard scan-code reader. Oversamples the PS/2 clock and data lines on the system clock instead of clocking logic from the PS/2 clock. Adds a glitch filter, framing, parity and timeout checks, and a scan-code FIFO with a valid/ready pop interface. Sits between the keyboard pins and the key-decode logic.

Parameters:
DATA_BITS, 8, payload bits per frame, sent LSB first.
ODD_PARITY, 1, 1 = odd parity (PS/2 standard); 0 = even parity.
FILTER_LEN, 8, consecutive equal system-clock samples needed to accept a line level change (>=2).
TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before a partial frame is abandoned.
FIFO_DEPTH, 4, stored codes; power of two, >=2.

Ports:
i_clock  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock pin; asynchronous; idles high.
ps2_data  in  1  raw PS/2 data pin; asynchronous; idles high.
o_valid  out  1  FIFO not empty; o_code is valid.
o_code  out  DATA_BITS  code at the FIFO head.
i_ready  in  1  pop request; a pop occurs when o_valid && i_ready.
o_parity_err  out  1  one-cycle pulse: parity mismatch; frame dropped.
o_frame_err  out  1  one-cycle pulse: start bit 1 or stop bit 0; frame dropped.
o_timeout  out  1  one-cycle pulse: partial frame abandoned.
o_overflow  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE; FIFO is empty; all outputs are 0; o_code is 0; synchroniser and filter state preset to 1 (idle high).
- Input conditioning: each pin passes through a 2-flop synchroniser, then the filter. The filtered level changes only after FILTER_LEN consecutive samples differ from the current filtered level.
- Edge detect: a filtered ps2_clk 1->0 transition generates a one-cycle fall strobe. All bit sampling uses filtered ps2_data in that same cycle.
- FSM, advanced only on fall strobes except for the timeout:
  - IDLE: data=0 -> DATA with bit count 0. Data=1 -> o_frame_err pulse; stay in IDLE.
  - DATA: shift the bit into position count (LSB first). After DATA_BITS bits -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: stop bit=1 and parity OK -> push the code; stop bit=0 -> o_frame_err. Either way -> IDLE.
  - Parity OK means XOR(data, parity bit) == ODD_PARITY. On mismatch with stop=1, pulse o_parity_err. If both checks fail, pulse only o_frame_err.
- Timeout: the idle counter resets on every fall strobe and runs while the FSM is not in IDLE. On reaching TIMEOUT_CYCLES -> IDLE, o_timeout pulse, partial data discarded. The counter is $clog2(TIMEOUT_CYCLES+1) wide and saturates.
- Push latency: o_valid rises the cycle after the fall strobe of the stop bit, when the FIFO was empty.
- FIFO:
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Empty: o_valid=0; i_ready is ignored.
  - Full with a push and no pop: the code is dropped, o_overflow pulses, contents are unchanged.
  - Full with a push and a pop in the same cycle: both occur; no overflow.
  - Empty with a push: o_valid=1 next cycle; a same-cycle pop is impossible because o_valid is still 0.
- o_code is combinational from the FIFO head and is held stable while o_valid=1 && !i_ready.
- Error pulses are mutually exclusive within one cycle, except o_overflow, which cannot coincide with the others.
- The bit counter is $clog2(DATA_BITS+1) wide.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP);
  - PS2_IDLE_LEVEL=1;
  - a parity-check function parameterised by ODD_PARITY.
- Sub-module ps2_sync_filter (parameter FILTER_LEN; ports i_clock, reset, raw in, filtered out), instantiated once for clock and once for data.
- The FIFO stays inline.

Test Plan:
- Send 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 12.5 kHz PS/2 clock -> o_valid=1, o_code=0x1C; pop with i_ready=1 -> o_valid=0.
- Send 0x1C with parity bit 1 -> single o_parity_err pulse; o_valid stays 0. Then send 0xF0 (parity 1) -> o_code=0xF0.
- Send 0x1C with stop bit 0 -> o_frame_err pulse; no push. A start bit of 1 -> o_frame_err and FSM remains in IDLE.
- Send start + 4 data bits, then hold lines high -> o_timeout exactly TIMEOUT_CYCLES after the last fall. A following 0x1C frame is received correctly.
- Pulse ps2_clk low for FILTER_LEN-1 cycles mid-frame -> no bit sampled; the frame completes with the correct code.
- FIFO_DEPTH=4, i_ready=0, send 0x01..0x05 -> o_overflow on the fifth frame. Pops return 0x01..0x04 in order. Push and pop in the same cycle while full -> no overflow, count unchanged.
